// File: rtl/ro_queue_pkg.sv
// Shared defaults and helpers for the read-operand queue.
package ro_queue_pkg;

    localparam int RO_DEF_P_ISSUE_WIDTH  = 1;
    localparam int RO_DEF_P_RO_DEPTH     = 1;
    localparam int RO_DEF_DW             = 64;
    localparam int RO_DEF_PRF_AW         = 6;
    localparam int RO_DEF_WB_W           = 2;
    localparam int RO_DEF_PAYLOAD_W      = 128;
    localparam int RO_DEF_PIPEBUF_BYPASS = 1;

    // A depth-1 queue still needs a 1-bit pointer to index its single slot.
    function automatic int ptr_w(input int p_depth);
        return (p_depth < 1) ? 1 : p_depth;
    endfunction

endpackage

// File: rtl/ro_queue_opd_sel.sv
// One operand slot: writeback tag compare at enqueue, registered hit, capture mux one cycle later.
module ro_opd_sel
    import ro_queue_pkg::*;
#(
    parameter int DW   = RO_DEF_DW,
    parameter int AW   = RO_DEF_PRF_AW,
    parameter int WB_W = RO_DEF_WB_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               re,
    input  logic [AW-1:0]      tag,
    input  logic [WB_W-1:0]    wb_we,
    input  logic [WB_W*AW-1:0] wb_prd,
    input  logic [WB_W*DW-1:0] wb_dat,
    input  logic [DW-1:0]      prf_rdata,
    output logic [DW-1:0]      operand
);

    logic          re_d, re_q;
    logic          match_d, match_q;
    logic [DW-1:0] dat_d, dat_q;
    logic          hit;
    logic [DW-1:0] hit_dat;

    always_comb begin
        hit     = 1'b0;
        hit_dat = '0;
        // Walk from the highest port down so the lowest matching port wins.
        for (int k = WB_W - 1; k >= 0; k--) begin
            if (wb_we[k] && (wb_prd[k*AW +: AW] == tag)) begin
                hit     = 1'b1;
                hit_dat = wb_dat[k*DW +: DW];
            end
        end
        re_d    = re_q;
        match_d = match_q;
        dat_d   = dat_q;
        if (en) begin
            re_d    = re;
            match_d = re & hit;
            dat_d   = hit_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            re_q    <= re_d;
            match_q <= match_d;
        end
    end

    always_ff @(posedge clk) begin
        dat_q <= dat_d;
    end

    assign operand = re_q ? (match_q ? dat_q : prf_rdata) : '0;

endmodule

// File: rtl/ro_queue.sv
// Read-operand queue between issue and execute: PRF read on enqueue, capture one cycle later.
module ro_queue
    import ro_queue_pkg::*;
#(
    parameter int CONFIG_P_ISSUE_WIDTH  = RO_DEF_P_ISSUE_WIDTH,
    parameter int CONFIG_P_RO_DEPTH     = RO_DEF_P_RO_DEPTH,
    parameter int CONFIG_DW             = RO_DEF_DW,
    parameter int CONFIG_PRF_AW         = RO_DEF_PRF_AW,
    parameter int CONFIG_WB_W           = RO_DEF_WB_W,
    parameter int CONFIG_PAYLOAD_W      = RO_DEF_PAYLOAD_W,
    parameter int CONFIG_PIPEBUF_BYPASS = RO_DEF_PIPEBUF_BYPASS,
    localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH,
    localparam int DW = CONFIG_DW,
    localparam int AW = CONFIG_PRF_AW,
    localparam int PW = CONFIG_PAYLOAD_W,
    localparam int CW = CONFIG_P_RO_DEPTH + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [IW-1:0]               a_valid,
    output logic                        a_ready,
    input  logic [IW*PW-1:0]            a_payload,
    input  logic [IW*AW-1:0]            a_prs1,
    input  logic [IW*AW-1:0]            a_prs2,
    input  logic [IW-1:0]               a_prs1_re,
    input  logic [IW-1:0]               a_prs2_re,
    output logic [IW*2-1:0]             prf_RE,
    output logic [IW*2*AW-1:0]          prf_RADDR,
    input  logic [IW*2*DW-1:0]          prf_RDATA,
    input  logic [CONFIG_WB_W-1:0]      wb_we,
    input  logic [CONFIG_WB_W*AW-1:0]   wb_prd,
    input  logic [CONFIG_WB_W*DW-1:0]   wb_dat,
    output logic [IW-1:0]               ex_valid,
    input  logic [IW-1:0]               ex_ready,
    output logic [IW*PW-1:0]            ex_payload,
    output logic [IW*DW-1:0]            ex_operand1,
    output logic [IW*DW-1:0]            ex_operand2,
    output logic [CW-1:0]               ex_count
);

    localparam int DEPTH = 1 << CONFIG_P_RO_DEPTH;
    localparam int PTRW  = ptr_w(CONFIG_P_RO_DEPTH);

    logic [PTRW-1:0]  wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]    count_d, count_q;
    logic             cap_pend_d, cap_pend_q;
    logic [PTRW-1:0]  cap_idx_d, cap_idx_q;
    logic [DEPTH-1:0] captured_d, captured_q;

    logic [IW-1:0]    mask_mem [DEPTH];
    logic [IW*PW-1:0] pay_mem  [DEPTH];
    logic [IW*DW-1:0] opd1_mem [DEPTH];
    logic [IW*DW-1:0] opd2_mem [DEPTH];

    logic [IW*DW-1:0] cap_opd1, cap_opd2;
    logic             full, head_valid, head_capturing, head_rdy, push, pop;
    logic [IW-1:0]    head_mask;

    assign full           = (count_q == CW'(DEPTH));
    assign head_valid     = (count_q != '0);
    assign head_mask      = mask_mem[rd_ptr_q];
    assign head_capturing = cap_pend_q & (cap_idx_q == rd_ptr_q);
    assign head_rdy       = captured_q[rd_ptr_q] | head_capturing;
    assign pop            = head_valid & head_rdy & (&(ex_ready | ~head_mask));
    assign a_ready        = ~flush & (~full | ((CONFIG_PIPEBUF_BYPASS != 0) & pop));
    assign push           = (|a_valid) & a_ready;

    for (genvar i = 0; i < IW; i++) begin : g_lane
        assign prf_RE[2*i]                  = push & a_valid[i] & a_prs1_re[i];
        assign prf_RE[2*i+1]                = push & a_valid[i] & a_prs2_re[i];
        assign prf_RADDR[(2*i)*AW +: AW]    = a_prs1[i*AW +: AW];
        assign prf_RADDR[(2*i+1)*AW +: AW]  = a_prs2[i*AW +: AW];

        ro_opd_sel #(.DW(DW), .AW(AW), .WB_W(CONFIG_WB_W)) u_opd1 (
            .clk       (clk),
            .rst       (rst),
            .en        (push),
            .re        (a_valid[i] & a_prs1_re[i]),
            .tag       (a_prs1[i*AW +: AW]),
            .wb_we     (wb_we),
            .wb_prd    (wb_prd),
            .wb_dat    (wb_dat),
            .prf_rdata (prf_RDATA[(2*i)*DW +: DW]),
            .operand   (cap_opd1[i*DW +: DW])
        );

        ro_opd_sel #(.DW(DW), .AW(AW), .WB_W(CONFIG_WB_W)) u_opd2 (
            .clk       (clk),
            .rst       (rst),
            .en        (push),
            .re        (a_valid[i] & a_prs2_re[i]),
            .tag       (a_prs2[i*AW +: AW]),
            .wb_we     (wb_we),
            .wb_prd    (wb_prd),
            .wb_dat    (wb_dat),
            .prf_rdata (prf_RDATA[(2*i+1)*DW +: DW]),
            .operand   (cap_opd2[i*DW +: DW])
        );
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cap_pend_d = push;
        cap_idx_d  = wr_ptr_q;
        captured_d = captured_q;
        if (cap_pend_q) captured_d[cap_idx_q] = 1'b1;
        // A fresh push must clear its slot even if a capture lands on it the same cycle.
        if (push) begin
            captured_d[wr_ptr_q] = 1'b0;
            wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            cap_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cap_pend_q <= 1'b0;
            cap_idx_q  <= '0;
            captured_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cap_pend_q <= cap_pend_d;
            cap_idx_q  <= cap_idx_d;
            captured_q <= captured_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr_q] <= a_valid;
            pay_mem[wr_ptr_q]  <= a_payload;
        end
        if (cap_pend_q) begin
            opd1_mem[cap_idx_q] <= cap_opd1;
            opd2_mem[cap_idx_q] <= cap_opd2;
        end
    end

    assign ex_valid    = head_valid ? head_mask : '0;
    assign ex_payload  = pay_mem[rd_ptr_q];
    assign ex_operand1 = head_capturing ? cap_opd1 : opd1_mem[rd_ptr_q];
    assign ex_operand2 = head_capturing ? cap_opd2 : opd2_mem[rd_ptr_q];
    assign ex_count    = count_q;

endmodule

// File: tb/tb_ro_queue.sv
// Directed bench for ro_queue at IW=2, depth 2, with a one-cycle-latency PRF model.
module tb_ro_queue;

    logic         clk, rst, flush;
    logic [1:0]   a_valid, a_prs1_re, a_prs2_re, ex_valid, ex_ready, wb_we;
    logic         a_ready;
    logic [255:0] a_payload, ex_payload;
    logic [11:0]  a_prs1, a_prs2, wb_prd;
    logic [3:0]   prf_re;
    logic [23:0]  prf_raddr;
    logic [255:0] prf_rdata;
    logic [127:0] wb_dat, ex_operand1, ex_operand2;
    logic [1:0]   ex_count;
    logic [63:0]  prf_mem [64];

    int n_pass = 0;
    int n_total = 0;

    ro_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .a_valid(a_valid), .a_ready(a_ready), .a_payload(a_payload),
        .a_prs1(a_prs1), .a_prs2(a_prs2), .a_prs1_re(a_prs1_re), .a_prs2_re(a_prs2_re),
        .prf_RE(prf_re), .prf_RADDR(prf_raddr), .prf_RDATA(prf_rdata),
        .wb_we(wb_we), .wb_prd(wb_prd), .wb_dat(wb_dat),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_payload(ex_payload),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_count(ex_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            prf_rdata[j*64 +: 64] <= prf_re[j] ? prf_mem[prf_raddr[j*6 +: 6]] : 64'h0;
    end

    typedef struct {
        logic [1:0]   av;
        logic [11:0]  prs1;
        logic [11:0]  prs2;
        logic [1:0]   re1;
        logic [1:0]   re2;
        logic [1:0]   we;
        logic [11:0]  prd;
        logic [127:0] dat;
        logic [3:0]   exp_re;
        logic [127:0] exp_op1;
        logic [127:0] exp_op2;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 2'b00; a_prs1 = '0; a_prs2 = '0; a_prs1_re = 2'b00; a_prs2_re = 2'b00;
        a_payload = '0; wb_we = 2'b00; wb_prd = '0; wb_dat = '0;
    endtask

    task automatic offer(input logic [1:0] av, input logic [5:0] tag0, input logic [255:0] pay);
        a_valid = av; a_prs1 = {6'd0, tag0}; a_prs1_re = 2'b01; a_prs2_re = 2'b00; a_payload = pay;
    endtask

    logic [255:0] pay_g1, pay_g2, pay_g3;

    initial begin
        for (int i = 0; i < 64; i++) prf_mem[i] = 64'h1000 + 64'(i);
        prf_mem[5] = 64'h1234;
        prf_mem[7] = 64'h55;
        pay_g1 = {2{128'h11}};
        pay_g2 = {2{128'h22}};
        pay_g3 = {2{128'h33}};

        //          av     prs1              prs2               re1    re2    we     prd              dat                     exp_re   exp_op1                      exp_op2
        vecs[0] = '{2'b01, {6'd0, 6'd5},     12'h0,             2'b01, 2'b00, 2'b00, 12'h0,           128'h0,                 4'b0001, {64'h0, 64'h1234},           128'h0};
        vecs[1] = '{2'b01, 12'h0,            {6'd0, 6'd7},      2'b00, 2'b01, 2'b01, {6'd0, 6'd7},    {64'h0, 64'hAA},        4'b0010, 128'h0,                      {64'h0, 64'hAA}};
        vecs[2] = '{2'b01, 12'h0,            {6'd0, 6'd7},      2'b00, 2'b01, 2'b11, {6'd7, 6'd7},    {64'hBB, 64'hAA},       4'b0010, 128'h0,                      {64'h0, 64'hAA}};
        vecs[3] = '{2'b01, 12'h0,            {6'd0, 6'd7},      2'b00, 2'b01, 2'b11, {6'd7, 6'd3},    {64'hBB, 64'hAA},       4'b0010, 128'h0,                      {64'h0, 64'hBB}};
        vecs[4] = '{2'b01, 12'h0,            {6'd0, 6'd7},      2'b00, 2'b01, 2'b00, {6'd7, 6'd7},    {64'hBB, 64'hAA},       4'b0010, 128'h0,                      {64'h0, 64'h55}};
        vecs[5] = '{2'b11, {6'd3, 6'd1},     {6'd4, 6'd2},      2'b11, 2'b11, 2'b00, 12'h0,           128'h0,                 4'b1111, {64'h1003, 64'h1001},        {64'h1004, 64'h1002}};
        vecs[6] = '{2'b10, {6'd9, 6'd1},     {6'd10, 6'd0},     2'b01, 2'b10, 2'b01, {6'd0, 6'd9},    {64'h0, 64'hCC},        4'b1000, 128'h0,                      {64'h100A, 64'h0}};
        vecs[7] = '{2'b11, {6'd12, 6'd12},   12'h0,             2'b11, 2'b00, 2'b10, {6'd12, 6'd12},  {64'hDD, 64'hEE},       4'b0101, {64'hDD, 64'hDD},            128'h0};

        rst = 1'b0; flush = 1'b0; ex_ready = 2'b11;
        idle_inputs();
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_a_ready", 256'(a_ready), 256'(1'b1));
        check("rst_ex_valid", 256'(ex_valid), 256'(2'b00));
        check("rst_count", 256'(ex_count), 256'(2'd0));
        check("rst_prf_re", 256'(prf_re), 256'(4'b0000));

        for (int v = 0; v < 8; v++) begin
            a_valid = vecs[v].av; a_prs1 = vecs[v].prs1; a_prs2 = vecs[v].prs2;
            a_prs1_re = vecs[v].re1; a_prs2_re = vecs[v].re2;
            wb_we = vecs[v].we; wb_prd = vecs[v].prd; wb_dat = vecs[v].dat;
            ex_ready = 2'b11;
            #1;
            check($sformatf("v%0d_prf_re", v), 256'(prf_re), 256'(vecs[v].exp_re));
            check($sformatf("v%0d_raddr", v), 256'(prf_raddr),
                  256'({vecs[v].prs2[11:6], vecs[v].prs1[11:6], vecs[v].prs2[5:0], vecs[v].prs1[5:0]}));
            check($sformatf("v%0d_ex_valid_T", v), 256'(ex_valid), 256'(2'b00));
            tick();
            idle_inputs();
            #1;
            check($sformatf("v%0d_ex_valid", v), 256'(ex_valid), 256'(vecs[v].av));
            check($sformatf("v%0d_op1", v), 256'(ex_operand1), 256'(vecs[v].exp_op1));
            check($sformatf("v%0d_op2", v), 256'(ex_operand2), 256'(vecs[v].exp_op2));
            tick();
            check($sformatf("v%0d_count_after_pop", v), 256'(ex_count), 256'(2'd0));
        end

        // Back-pressure: fill, refuse third, bypass-accept on pop, in-order drain.
        ex_ready = 2'b00;
        offer(2'b11, 6'd1, pay_g1); tick();
        offer(2'b11, 6'd2, pay_g2); tick();
        offer(2'b11, 6'd3, pay_g3); #1;
        check("full_a_ready", 256'(a_ready), 256'(1'b0));
        check("full_count", 256'(ex_count), 256'(2'd2));
        check("full_payload", ex_payload, pay_g1);
        tick();
        check("stall_payload", ex_payload, pay_g1);
        check("stall_op1", 256'(ex_operand1), 256'({64'h0, 64'h1001}));
        check("stall_count", 256'(ex_count), 256'(2'd2));
        ex_ready = 2'b11; #1;
        check("bypass_a_ready", 256'(a_ready), 256'(1'b1));
        tick();
        idle_inputs();
        #1;
        check("bypass_count", 256'(ex_count), 256'(2'd2));
        check("g2_payload", ex_payload, pay_g2);
        check("g2_op1", 256'(ex_operand1), 256'({64'h0, 64'h1002}));
        tick();
        check("g3_payload", ex_payload, pay_g3);
        check("g3_op1", 256'(ex_operand1), 256'({64'h0, 64'h1003}));
        check("g3_count", 256'(ex_count), 256'(2'd1));
        tick();
        check("drain_count", 256'(ex_count), 256'(2'd0));
        check("drain_ex_valid", 256'(ex_valid), 256'(2'b00));

        // Partial ready never splits a group.
        ex_ready = 2'b00;
        offer(2'b11, 6'd4, pay_g1); tick();
        idle_inputs();
        ex_ready = 2'b01; #1;
        check("partial_ex_valid", 256'(ex_valid), 256'(2'b11));
        tick();
        check("partial_hold_count", 256'(ex_count), 256'(2'd1));
        check("partial_hold_valid", 256'(ex_valid), 256'(2'b11));
        check("partial_hold_op1", 256'(ex_operand1), 256'({64'h0, 64'h1004}));
        ex_ready = 2'b11;
        tick();
        check("partial_pop_count", 256'(ex_count), 256'(2'd0));

        // Flush dominates a same-cycle push; the flushed group never appears.
        ex_ready = 2'b00;
        offer(2'b01, 6'd1, pay_g1); tick();
        offer(2'b01, 6'd2, pay_g2); flush = 1'b1; #1;
        check("flush_a_ready", 256'(a_ready), 256'(1'b0));
        tick();
        flush = 1'b0;
        idle_inputs();
        #1;
        check("flush_count", 256'(ex_count), 256'(2'd0));
        check("flush_ex_valid", 256'(ex_valid), 256'(2'b00));
        tick();
        check("flush_stays_empty", 256'(ex_valid), 256'(2'b00));
        ex_ready = 2'b11;
        offer(2'b01, 6'd5, pay_g3); tick();
        idle_inputs();
        #1;
        check("post_flush_payload", ex_payload, pay_g3);
        check("post_flush_op1", 256'(ex_operand1), 256'({64'h0, 64'h1234}));
        tick();
        check("post_flush_count", 256'(ex_count), 256'(2'd0));

        // Asynchronous reset while a capture is pending.
        ex_ready = 2'b00;
        offer(2'b01, 6'd5, pay_g1); tick();
        idle_inputs();
        check("pre_rst_valid", 256'(ex_valid), 256'(2'b01));
        #1 rst = 1'b0;
        #1;
        check("async_rst_valid", 256'(ex_valid), 256'(2'b00));
        check("async_rst_count", 256'(ex_count), 256'(2'd0));
        #1 rst = 1'b1;
        tick();
        check("after_rst_count", 256'(ex_count), 256'(2'd0));
        check("after_rst_a_ready", 256'(a_ready), 256'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
